// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and framing constants for the one-bit-per-clock serial link.
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_W = 8;
endpackage

// File: rtl/serial_tx.sv
// serial_tx: framed byte transmitter (start, 8 data LSB-first, parity, stop bits), one bit per clock.
module serial_tx
  import serial_pkg::*;
#(
  parameter logic PARITY_ODD = 1'b1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  state_t r_state;
  logic [2:0] r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic r_par, r_stop_cnt, r_out, r_busy, r_done;
  logic w_last_stop, w_xfer;
  assign w_last_stop = r_stop_cnt == LAST_STOP;
  assign in_ready = r_state == IDLE || (r_state == STOP && w_last_stop);
  assign w_xfer = in_valid && in_ready;
  assign out = r_out;
  assign busy = r_busy;
  assign frame_done = r_done;
  // out/busy/frame_done are loaded with the value for the state being entered, so they are pure flops
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_shreg <= '0;
      r_par <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_out <= STOP_BIT;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_xfer) begin
          r_state <= START;
          r_shreg <= in_data;
          r_par <= ^in_data ^ PARITY_ODD;
          r_out <= START_BIT;
          r_busy <= 1'b1;
        end
        START: begin
          r_state <= DATA;
          r_cnt <= '0;
          r_out <= r_shreg[0];
          r_shreg <= r_shreg >> 1;
        end
        DATA: if (r_cnt == 3'd7) begin
          r_state <= PARITY;
          r_cnt <= '0;
          r_out <= r_par;
        end else begin
          r_cnt <= r_cnt + 3'd1;
          r_out <= r_shreg[0];
          r_shreg <= r_shreg >> 1;
        end
        PARITY: begin
          r_state <= STOP;
          r_stop_cnt <= 1'b0;
          r_out <= STOP_BIT;
          r_done <= LAST_STOP == 1'b0;
        end
        STOP: if (!w_last_stop) begin
          r_stop_cnt <= r_stop_cnt + 1'b1;
          r_done <= 1'b1;
        end else if (w_xfer) begin
          r_state <= START;
          r_stop_cnt <= 1'b0;
          r_shreg <= in_data;
          r_par <= ^in_data ^ PARITY_ODD;
          r_out <= START_BIT;
        end else begin
          r_state <= IDLE;
          r_stop_cnt <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_out <= STOP_BIT;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: three serial_tx variants checked against a frame-position reference model plus directed vectors.
module tb_serial_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v[3];
  logic [7:0] d[3];
  logic rdy[3], o[3], bsy[3], fd[3];
  int checks = 0, errors = 0, cyc = 0;
  int pos[3] = '{-1, -1, -1};
  logic [7:0] cur[3];
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx #(.PARITY_ODD(1'b1), .STOP_BITS(1)) u0 (.clk(clk), .areset_n(rst_n), .in_valid(v[0]),
    .in_data(d[0]), .in_ready(rdy[0]), .out(o[0]), .busy(bsy[0]), .frame_done(fd[0]));
  serial_tx #(.PARITY_ODD(1'b1), .STOP_BITS(2)) u1 (.clk(clk), .areset_n(rst_n), .in_valid(v[1]),
    .in_data(d[1]), .in_ready(rdy[1]), .out(o[1]), .busy(bsy[1]), .frame_done(fd[1]));
  serial_tx #(.PARITY_ODD(1'b0), .STOP_BITS(1)) u2 (.clk(clk), .areset_n(rst_n), .in_valid(v[2]),
    .in_data(d[2]), .in_ready(rdy[2]), .out(o[2]), .busy(bsy[2]), .frame_done(fd[2]));

  function automatic int len_of(int k);
    return k == 1 ? 12 : 11;
  endfunction

  function automatic logic odd_of(int k);
    return k != 2;
  endfunction

  // line value at position p of a frame: start, d0..d7, parity, then stop bits
  function automatic logic fbit(logic [7:0] dt, int p, logic od);
    if (p == 0) return 1'b0;
    if (p <= 8) return dt[p-1];
    if (p == 9) return ^dt ^ od;
    return 1'b1;
  endfunction

  // model: pos = cycle index within the current frame, -1 when idle
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) pos[k] = -1;
      else begin
        automatic bit r = pos[k] < 0 || pos[k] == len_of(k) - 1;
        if (pos[k] >= 0) pos[k] = pos[k] + 1;
        if (pos[k] == len_of(k)) pos[k] = -1;
        if (v[k] && r) begin
          pos[k] = 0;
          cur[k] = d[k];
        end
      end
    end
  end

  task automatic chk(string name, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d at cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    for (int k = 0; k < 3; k++) begin
      automatic int p = pos[k];
      chk("out", k, int'(o[k]), int'(p < 0 ? 1'b1 : fbit(cur[k], p, odd_of(k))));
      chk("busy", k, int'(bsy[k]), int'(p >= 0));
      chk("frame_done", k, int'(fd[k]), int'(p == len_of(k) - 1));
      chk("in_ready", k, int'(rdy[k]), int'(p < 0 || p == len_of(k) - 1));
    end
  end

  typedef struct {
    int k;
    logic [7:0] data;
    logic par;
    int done_off;
  } vec_t;

  // offer one byte to an idle dut, scramble in_data mid-frame, capture 12 cycles of line
  task automatic run_vec(vec_t t);
    logic [11:0] ln, dn, rd;
    @(negedge clk);
    v[t.k] = 1'b1;
    d[t.k] = t.data;
    @(posedge clk);
    #1;
    v[t.k] = 1'b0;
    d[t.k] = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ln[i] = o[t.k];
      dn[i] = fd[t.k];
      rd[i] = rdy[t.k];
    end
    chk("vec_start", t.k, int'(ln[0]), 0);
    chk("vec_data", t.k, int'(ln[8:1]), int'(t.data));
    chk("vec_parity", t.k, int'(ln[9]), int'(t.par));
    chk("vec_stop", t.k, int'(ln[11:10]), 3);
    chk("vec_done_pos", t.k, int'(dn), int'(12'b1 << (t.done_off - 1)));
    if (t.k == 1) begin
      chk("vec_ready_stop1", t.k, int'(rd[10]), 0);
      chk("vec_ready_stop2", t.k, int'(rd[11]), 1);
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    int e1, e2, drops;
    bit got;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0;
      d[k] = 8'h00;
    end
    tbl[0] = '{0, 8'hA5, 1'b1, 11};
    tbl[1] = '{0, 8'h01, 1'b0, 11};
    tbl[2] = '{0, 8'h00, 1'b1, 11};
    tbl[3] = '{0, 8'h3C, 1'b1, 11};
    tbl[4] = '{1, 8'h80, 1'b0, 12};
    tbl[5] = '{2, 8'hA5, 1'b0, 11};
    tbl[6] = '{2, 8'h07, 1'b1, 11};
    tbl[7] = '{2, 8'hFF, 1'b0, 11};
    #2;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    // back-to-back: second byte must be taken in the first frame's stop cycle
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'h3C;
    @(posedge clk);
    #1;
    e1 = cyc;
    d[0] = 8'hFF;
    got = 1'b0;
    drops = 0;
    e2 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!bsy[0]) drops++;
      if (rdy[0]) begin
        @(posedge clk);
        #1;
        e2 = cyc;
        got = 1'b1;
      end
    end
    v[0] = 1'b0;
    chk("b2b_accepted", 0, int'(got), 1);
    chk("b2b_spacing", 0, e2 - e1, 11);
    chk("b2b_busy_drops", 0, drops, 0);
    repeat (14) @(negedge clk);

    // asynchronous reset in the middle of an 0xA5 frame (line is 0 in cycle E+5)
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'hA5;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_out", 0, int'(o[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("async_out", 0, int'(o[0]), 1);
    chk("async_busy", 0, int'(bsy[0]), 0);
    chk("async_done", 0, int'(fd[0]), 0);
    chk("async_ready", 0, int'(rdy[0]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec('{0, 8'h5A, 1'b1, 11});

    // randomized traffic on all three variants, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        v[k] = $urandom_range(0, 3) != 0;
        d[k] = 8'($urandom);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) v[k] = 1'b0;
    repeat (15) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
